button_debounce_bank: RTL and testbench

//  Parametrised N-channel successor to the fixed five-button debouncer used on the board top level.

---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_channel.sv | 155 +++++++++++++++
 rtl/button_debounce_bank.sv | 86 ++++++++
 tb/tb_button_debounce_bank.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// +-----------------------------------------------------------------------------+
// | debounce_pkg: shared state encoding and width helper for the debounce bank. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_PEND = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_PEND = 2'd3
    } db_state_e;

    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// +-----------------------------------------------------------------------------+
// | debounce_channel: synchroniser, settle FSM and press/release pulses for one |
// | input. Optional auto-repeat on press_o when DEBOUNCE_REPEAT_EN is defined.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_TICKS  = 10000,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic clk,
    input  logic cpu_resetn,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic level_nxt_o,
    output logic press_o,
    output logic release_o
);

    localparam int             CW       = cnt_width(SETTLE_TICKS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_TICKS - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_w;
    db_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int             RW        = cnt_width(REPEAT_DELAY + REPEAT_PERIOD);
    localparam logic [RW-1:0]  RPT_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]  RPT_NEXT  = RW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
    localparam logic [RW-1:0]  RPT_BASE  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0]  RPT_ONE   = RW'(1);
    logic [RW-1:0] rpt_q, rpt_d;
`endif

    assign sync_w = sync_q[SYNC_STAGES-1];

    // The disagreeing tick seen in a stable state is the first of the
    // SETTLE_TICKS, so pend states start counting at one on a tick.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
        rpt_d     = rpt_q;
`endif
        case (state_q)
            ST_LOW, ST_RISE_PEND: begin
                if (!sync_w) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
                        rpt_d   = '0;
`endif
                    end else begin
                        state_d = ST_RISE_PEND;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_RISE_PEND;
                end
            end
            ST_HIGH, ST_FALL_PEND: begin
                if (sync_w) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
`ifdef DEBOUNCE_REPEAT_EN
                    if (tick_i && (state_q == ST_HIGH)) begin
                        if (rpt_q == RPT_FIRST) begin
                            press_d = 1'b1;
                            rpt_d   = rpt_q + RPT_ONE;
                        end else if (rpt_q == RPT_NEXT) begin
                            press_d = 1'b1;
                            rpt_d   = RPT_BASE;
                        end else begin
                            rpt_d   = rpt_q + RPT_ONE;
                        end
                    end
`endif
                end else if (tick_i) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d   = ST_LOW;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
                        rpt_d     = '0;
`endif
                    end else begin
                        state_d = ST_FALL_PEND;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_FALL_PEND;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            sync_q    <= '0;
            state_q   <= ST_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
            rpt_q     <= '0;
`endif
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
`ifdef DEBOUNCE_REPEAT_EN
            rpt_q     <= rpt_d;
`endif
        end
    end

    assign level_o     = level_q;
    assign level_nxt_o = level_d;
    assign press_o     = press_q;
    assign release_o   = release_q;

endmodule

`default_nettype wire

// File: rtl/button_debounce_bank.sv
// +-----------------------------------------------------------------------------+
// | button_debounce_bank: N-channel debouncer with a shared tick prescaler.     |
// | Define DEBOUNCE_REPEAT_EN to enable auto-repeat press pulses.               |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module button_debounce_bank
    import debounce_pkg::*;
#(
    parameter int N_CH          = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int TICK_DIV      = 100,
    parameter int SETTLE_TICKS  = 10000,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic            clk,
    input  logic            cpu_resetn,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic            any_o
);

    logic            tick_w;
    logic [N_CH-1:0] level_nxt_w;
    logic            any_q;

    generate
        if (TICK_DIV <= 1) begin : g_tick_every
            assign tick_w = 1'b1;
        end else begin : g_prescaler
            localparam int            PW       = cnt_width(TICK_DIV - 1);
            localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
            logic [PW-1:0] pre_q;

            always_ff @(posedge clk or negedge cpu_resetn) begin
                if (!cpu_resetn) begin
                    pre_q <= '0;
                end else if (pre_q == PRE_LAST) begin
                    pre_q <= '0;
                end else begin
                    pre_q <= pre_q + PW'(1);
                end
            end

            assign tick_w = (pre_q == PRE_LAST);
        end
    endgenerate

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            debounce_channel #(
                .SYNC_STAGES   (SYNC_STAGES),
                .SETTLE_TICKS  (SETTLE_TICKS),
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD)
            ) u_channel (
                .clk         (clk),
                .cpu_resetn  (cpu_resetn),
                .tick_i      (tick_w),
                .btn_i       (btn_i[i]),
                .level_o     (level_o[i]),
                .level_nxt_o (level_nxt_w[i]),
                .press_o     (press_o[i]),
                .release_o   (release_o[i])
            );
        end
    endgenerate

    // Built from next-state levels so any_o moves in the same cycle as level_o.
    always_ff @(posedge clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |level_nxt_w;
        end
    end

    assign any_o = any_q;

endmodule

`default_nettype wire

// File: tb/tb_button_debounce_bank.sv
// +-----------------------------------------------------------------------------+
// | tb_button_debounce_bank: directed self-checking bench for the debounce bank.|
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_button_debounce_bank;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         cpu_resetn;
    logic [N-1:0] btn_i;
    logic [N-1:0] level_o;
    logic [N-1:0] press_o;
    logic [N-1:0] release_o;
    logic         any_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_debounce_bank #(
        .N_CH          (N),
        .SYNC_STAGES   (2),
        .TICK_DIV      (1),
        .SETTLE_TICKS  (8),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (10)
    ) dut (
        .clk        (clk),
        .cpu_resetn (cpu_resetn),
        .btn_i      (btn_i),
        .level_o    (level_o),
        .press_o    (press_o),
        .release_o  (release_o),
        .any_o      (any_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cpu_resetn = 1'b0;
        btn_i      = '0;
        repeat (3) cyc();
        checks++; if (level_o !== 5'b0)   begin errors++; $display("FAIL reset_level got %b want %b", level_o, 5'b0); end
        checks++; if (press_o !== 5'b0)   begin errors++; $display("FAIL reset_press got %b want %b", press_o, 5'b0); end
        checks++; if (release_o !== 5'b0) begin errors++; $display("FAIL reset_release got %b want %b", release_o, 5'b0); end
        checks++; if (any_o !== 1'b0)     begin errors++; $display("FAIL reset_any got %b want %b", any_o, 1'b0); end
        cpu_resetn = 1'b1;
        repeat (4) cyc();
        checks++; if (level_o !== 5'b0)   begin errors++; $display("FAIL idle_level got %b want %b", level_o, 5'b0); end
        checks++; if (press_o !== 5'b0)   begin errors++; $display("FAIL idle_press got %b want %b", press_o, 5'b0); end
    endtask

    task automatic test_single_press();
        logic [N-1:0] ep, el, er;
        btn_i[0] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            ep = (k == 10) ? 5'b00001 : 5'b00000;
`ifdef DEBOUNCE_REPEAT_EN
            if (k == 30) ep = 5'b00001;
`endif
            el = (k >= 10) ? 5'b00001 : 5'b00000;
            checks++; if (press_o !== ep)     begin errors++; $display("FAIL single_press k=%0d got %b want %b", k, press_o, ep); end
            checks++; if (level_o !== el)     begin errors++; $display("FAIL single_level k=%0d got %b want %b", k, level_o, el); end
            checks++; if (release_o !== 5'b0) begin errors++; $display("FAIL single_release k=%0d got %b want %b", k, release_o, 5'b0); end
        end
        btn_i[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            er = (k == 10) ? 5'b00001 : 5'b00000;
            el = (k < 10)  ? 5'b00001 : 5'b00000;
            checks++; if (release_o !== er) begin errors++; $display("FAIL single_rel_pulse k=%0d got %b want %b", k, release_o, er); end
            checks++; if (level_o !== el)   begin errors++; $display("FAIL single_rel_level k=%0d got %b want %b", k, level_o, el); end
            checks++; if (press_o !== 5'b0) begin errors++; $display("FAIL single_rel_press k=%0d got %b want %b", k, press_o, 5'b0); end
        end
    endtask

    task automatic test_glitch();
        btn_i[2] = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            cyc();
            if (k == 5) btn_i[2] = 1'b0;
            checks++; if (level_o !== 5'b0)   begin errors++; $display("FAIL glitch_level k=%0d got %b want %b", k, level_o, 5'b0); end
            checks++; if (press_o !== 5'b0)   begin errors++; $display("FAIL glitch_press k=%0d got %b want %b", k, press_o, 5'b0); end
            checks++; if (release_o !== 5'b0) begin errors++; $display("FAIL glitch_release k=%0d got %b want %b", k, release_o, 5'b0); end
        end
    endtask

    task automatic test_bounce();
        logic [N-1:0] ep, el, er;
        for (int t = 0; t < 4; t++) begin
            btn_i[1] = ~t[0];
            for (int k = 1; k <= 3; k++) begin
                cyc();
                checks++; if (press_o !== 5'b0) begin errors++; $display("FAIL bounce_press t=%0d got %b want %b", t, press_o, 5'b0); end
                checks++; if (level_o !== 5'b0) begin errors++; $display("FAIL bounce_level t=%0d got %b want %b", t, level_o, 5'b0); end
            end
        end
        btn_i[1] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            ep = (k == 10) ? 5'b00010 : 5'b00000;
            el = (k >= 10) ? 5'b00010 : 5'b00000;
            checks++; if (press_o !== ep) begin errors++; $display("FAIL bounce_settle_press k=%0d got %b want %b", k, press_o, ep); end
            checks++; if (level_o !== el) begin errors++; $display("FAIL bounce_settle_level k=%0d got %b want %b", k, level_o, el); end
        end
        btn_i[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            er = (k == 10) ? 5'b00010 : 5'b00000;
            checks++; if (release_o !== er) begin errors++; $display("FAIL bounce_release k=%0d got %b want %b", k, release_o, er); end
        end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] ep, el, er;
        logic         ea;
        btn_i = 5'b10010;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            ep = (k == 10) ? 5'b10010 : 5'b00000;
            el = (k >= 10) ? 5'b10010 : 5'b00000;
            ea = (k >= 10);
            checks++; if (press_o !== ep) begin errors++; $display("FAIL simul_press k=%0d got %b want %b", k, press_o, ep); end
            checks++; if (level_o !== el) begin errors++; $display("FAIL simul_level k=%0d got %b want %b", k, level_o, el); end
            checks++; if (any_o !== ea)   begin errors++; $display("FAIL simul_any k=%0d got %b want %b", k, any_o, ea); end
        end
        btn_i = 5'b00000;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            er = (k == 10) ? 5'b10010 : 5'b00000;
            ea = (k < 10);
            checks++; if (release_o !== er) begin errors++; $display("FAIL simul_release k=%0d got %b want %b", k, release_o, er); end
            checks++; if (any_o !== ea)     begin errors++; $display("FAIL simul_rel_any k=%0d got %b want %b", k, any_o, ea); end
            checks++; if (press_o !== 5'b0) begin errors++; $display("FAIL simul_rel_press k=%0d got %b want %b", k, press_o, 5'b0); end
        end
    endtask

    task automatic test_reset_held();
        logic [N-1:0] ep, er;
        btn_i[3] = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            ep = (k == 10) ? 5'b01000 : 5'b00000;
            checks++; if (press_o !== ep) begin errors++; $display("FAIL held_pre_press k=%0d got %b want %b", k, press_o, ep); end
        end
        checks++; if (level_o !== 5'b01000) begin errors++; $display("FAIL held_pre_level got %b want %b", level_o, 5'b01000); end
        cpu_resetn = 1'b0;
        #1;
        checks++; if (level_o !== 5'b0) begin errors++; $display("FAIL held_async_level got %b want %b", level_o, 5'b0); end
        checks++; if (any_o !== 1'b0)   begin errors++; $display("FAIL held_async_any got %b want %b", any_o, 1'b0); end
        cyc();
        cyc();
        cpu_resetn = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            ep = (k == 10) ? 5'b01000 : 5'b00000;
            checks++; if (press_o !== ep) begin errors++; $display("FAIL held_post_press k=%0d got %b want %b", k, press_o, ep); end
        end
        btn_i[3] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            er = (k == 10) ? 5'b01000 : 5'b00000;
            checks++; if (release_o !== er) begin errors++; $display("FAIL held_release k=%0d got %b want %b", k, release_o, er); end
        end
    endtask

    task automatic test_hold_long();
        logic [N-1:0] ep, er;
        btn_i[0] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            cyc();
            ep = (k == 10) ? 5'b00001 : 5'b00000;
`ifdef DEBOUNCE_REPEAT_EN
            if (k == 30 || k == 40 || k == 50 || k == 60) ep = 5'b00001;
`endif
            checks++; if (press_o !== ep) begin errors++; $display("FAIL hold_press k=%0d got %b want %b", k, press_o, ep); end
        end
        btn_i[0] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            cyc();
            er = (k == 10) ? 5'b00001 : 5'b00000;
            checks++; if (press_o !== 5'b0) begin errors++; $display("FAIL hold_rel_press k=%0d got %b want %b", k, press_o, 5'b0); end
            checks++; if (release_o !== er) begin errors++; $display("FAIL hold_release k=%0d got %b want %b", k, release_o, er); end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_held();
        test_hold_long();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
